// File: rtl/ft600_tx_arbiter_pkg.sv
// Shared constants, state encoding and header packing for the FT600 TX arbiter.
package ft600_arb_pkg;

  localparam logic [3:0] HDR_SYNC = 4'hA;
  localparam int         LEN_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } arb_state_e;

  // Header word: sync nibble, channel id, payload length in words.
  function automatic logic [15:0] hdr_pack(input logic [1:0] id, input logic [LEN_W-1:0] len);
    return {HDR_SYNC, id, len};
  endfunction

endpackage

// File: rtl/ft600_tx_arbiter_if.sv
// Channel-side sources and bridge TX write port of the arbiter.
interface ft600_tx_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 10
);
  logic [NUM_CH-1:0]       ch_req;
  logic [NUM_CH*LEN_W-1:0] ch_len;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH*16-1:0]    ch_data;
  logic [NUM_CH-1:0]       ch_rd;
  logic [NUM_CH-1:0]       ch_done;
  logic                    tx_en;
  logic [15:0]             tx_in;
  logic                    tx_full;

  modport master (
    input  ch_req, ch_len, ch_valid, ch_data, tx_full,
    output ch_rd, ch_done, tx_en, tx_in
  );

  modport slave (
    output ch_req, ch_len, ch_valid, ch_data, tx_full,
    input  ch_rd, ch_done, tx_en, tx_in
  );
endinterface

// File: rtl/ft600_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after last_ptr, cyclically.
module rr_select #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last_ptr,
  output logic              any,
  output logic [1:0]        id
);

  logic [3:0] req4;
  logic [1:0] idx;

  assign req4 = 4'(req);

  // Walk the ring starting just after last_ptr; the first hit wins.
  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = 2'((int'(last_ptr) + i) % NUM_CH);
      if (!any && req4[idx]) begin
        any = 1'b1;
        id  = idx;
      end
    end
  end

endmodule

// File: rtl/ft600_tx_arbiter.sv
// Packet-framing round-robin arbiter in front of the FT600 bridge TX write port.
module ft600_tx_arbiter #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  ft600_tx_arbiter_if.master         bus,
  output logic                       busy,
  output logic [1:0]                 grant_id
);
  import ft600_arb_pkg::*;

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] HDR  = ST_HDR;
  localparam logic [1:0] PAY  = ST_PAY;

  logic [1:0]             state;
  logic [LEN_W-1:0]       rem;
  logic [1:0]             last_ptr;
  logic [NUM_CH-1:0]      done_q;

  // Channel buses padded to four entries so a 2-bit id always indexes safely.
  logic [3:0][LEN_W-1:0]  len_a;
  logic [3:0][15:0]       data_a;
  logic [3:0]             valid_a;

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    if (i < NUM_CH) begin : g_real
      assign len_a[i]   = bus.ch_len[i*LEN_W +: LEN_W];
      assign data_a[i]  = bus.ch_data[i*16 +: 16];
      assign valid_a[i] = bus.ch_valid[i];
    end else begin : g_absent
      assign len_a[i]   = '0;
      assign data_a[i]  = '0;
      assign valid_a[i] = 1'b0;
    end
  end

  logic       sel_any;
  logic [1:0] sel_id;

  rr_select #(.NUM_CH(NUM_CH)) u_sel (
    .req      (bus.ch_req),
    .last_ptr (last_ptr),
    .any      (sel_any),
    .id       (sel_id)
  );

  logic [3:0] g_onehot;
  logic [3:0] rd4;
  logic       pay_wr;

  assign g_onehot = 4'b0001 << grant_id;
  assign pay_wr   = (state == PAY) && valid_a[grant_id] && !bus.tx_full;
  assign rd4      = pay_wr ? g_onehot : 4'b0000;

  // Write path: unregistered, straight from state, ch_valid and tx_full.
  always_comb begin
    bus.tx_en = 1'b0;
    bus.tx_in = '0;
    unique case (state)
      HDR: begin
        bus.tx_en = !bus.tx_full;
        bus.tx_in = hdr_pack(grant_id, rem);
      end
      PAY: begin
        bus.tx_en = pay_wr;
        bus.tx_in = data_a[grant_id];
      end
      default: ;
    endcase
  end

  assign bus.ch_rd   = rd4[NUM_CH-1:0];
  assign bus.ch_done = done_q;

  // Packet FSM: grant in IDLE, header, then payload until rem runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      grant_id <= '0;
      last_ptr <= 2'(NUM_CH - 1);
      done_q   <= '0;
      busy     <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state)
        IDLE: begin
          if (en && sel_any) begin
            grant_id <= sel_id;
            last_ptr <= sel_id;
            rem      <= len_a[sel_id];
            state    <= HDR;
            busy     <= 1'b1;
          end
        end
        HDR: begin
          if (!bus.tx_full) begin
            if (rem == '0) begin
              state  <= IDLE;
              busy   <= 1'b0;
              done_q <= g_onehot[NUM_CH-1:0];
            end else begin
              state <= PAY;
            end
          end
        end
        PAY: begin
          if (pay_wr) begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state  <= IDLE;
              busy   <= 1'b0;
              done_q <= g_onehot[NUM_CH-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
